// File: rtl/dmem_param.sv
// Byte-writable data memory with registered read, write-first same-address
// behaviour and a post-reset clear sequencer. DMEM_BOUNDS_CHECK_EN enables out-of-range detection.
module dmem_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   access_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    busy,
    output logic                    addr_err,
    output logic                    state_dbg
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Handshake: a request is accepted on any posedge where busy is low and
    // read_en/write_en is high; there is no backpressure once READY.
    state_t                 state, state_next;
    logic [IDX_W-1:0]       clr_cnt, clr_cnt_next;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]       idx;
    logic                   in_range;
    logic                   accept;
    logic                   wr_fire;
    logic                   rd_fire;
    logic [DATA_WIDTH-1:0]  merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == ST_INIT) begin
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
                state_next   = ST_READY;
                clr_cnt_next = '0;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    assign in_range = ({1'b0, access_addr} < DEPTH_A);
`else
    // Address wraps modulo DEPTH; upper address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{1'b0, access_addr};
    assign in_range    = 1'b1;
`endif

    assign idx     = access_addr[IDX_W-1:0];
    assign accept  = (state == ST_READY);
    assign wr_fire = accept && write_en && in_range;
    assign rd_fire = accept && read_en;

    // Post-write word: feeds both the array update and the write-first read path.
    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < NB; i++) begin
            if (wr_fire && byte_en[i]) begin
                merged[8*i +: 8] = write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_fire && byte_en[i]) begin
                    mem[idx][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_fire;
            if (rd_fire) begin
                read_data <= in_range ? merged : '0;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= accept && (read_en || write_en) && !in_range;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

    assign busy      = (state == ST_INIT);
    assign state_dbg = (state == ST_READY);

endmodule
